// File: rtl/regfile_pkg.sv
// Shared constants and enums for the register-file writeback port arbiter.
package regfile_pkg;

    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned ZERO_REG = 0;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LD  = 1'b1
    } req_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; purely combinational, history held by the caller.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic [1:0] req,
    input  req_e       last_grant,
    input  logic       en,
    output logic [1:0] gnt
);

    // Index 0 is the ALU, index 1 the load unit; a tie goes to whoever did not win last.
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (last_grant == REQ_LD) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-port sequencer/arbiter for the 32x32 register file (ALU vs load writeback).
// Define CLEAR_ON_RESET_EN to zero-clear x1..x31 after every reset.
module regfile_wb_arbiter #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_wd,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_rd,
    input  logic [DATA_W-1:0] ld_wd,
    output logic              WE3,
    output logic [ADDR_W-1:0] A3,
    output logic [DATA_W-1:0] WD3,
    output logic              busy,
    output logic [7:0]        stall_cnt
);

    import regfile_pkg::*;

    logic              run;
    logic [ADDR_W-1:0] clr_addr;
    logic [1:0]        gnt;
    logic              alu_fire;
    logic              ld_fire;
    req_e              last_grant_q;
    req_e              last_grant_d;
    logic              we3_d;
    logic [ADDR_W-1:0] a3_d;
    logic [DATA_W-1:0] wd3_d;
    logic [7:0]        stall_d;

`ifdef CLEAR_ON_RESET_EN
    state_e            state_q;
    state_e            state_d;
    logic [ADDR_W-1:0] clr_idx_q;
    logic [ADDR_W-1:0] clr_idx_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= ADDR_W'(1);
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Walk x1..x31 once, then hand the port to the requesters.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == ST_CLEAR) begin
            clr_idx_d = clr_idx_q + ADDR_W'(1);
            if (clr_idx_q == ADDR_W'(NUM_REGS - 1)) begin
                state_d = ST_RUN;
            end
        end
    end

    assign run      = (state_q == ST_RUN);
    assign clr_addr = clr_idx_q;
`else
    assign run      = 1'b1;
    assign clr_addr = '0;
`endif

    assign busy = !run;

    rr_arb2 u_arb (
        .req        ({ld_valid, alu_valid}),
        .last_grant (last_grant_q),
        .en         (run),
        .gnt        (gnt)
    );

    assign alu_ready = gnt[0];
    assign ld_ready  = gnt[1];
    assign alu_fire  = alu_valid && alu_ready;
    assign ld_fire   = ld_valid && ld_ready;

    // Next write-port value; address and data hold when nothing is accepted.
    always_comb begin
        we3_d        = 1'b0;
        a3_d         = A3;
        wd3_d        = WD3;
        last_grant_d = last_grant_q;
        stall_d      = stall_cnt;
        if (!run) begin
            we3_d = 1'b1;
            a3_d  = clr_addr;
            wd3_d = '0;
        end else if (alu_fire) begin
            we3_d        = (alu_rd != ADDR_W'(ZERO_REG));
            a3_d         = alu_rd;
            wd3_d        = alu_wd;
            last_grant_d = REQ_ALU;
        end else if (ld_fire) begin
            we3_d        = (ld_rd != ADDR_W'(ZERO_REG));
            a3_d         = ld_rd;
            wd3_d        = ld_wd;
            last_grant_d = REQ_LD;
        end
        if (run && ((alu_valid && !alu_ready) || (ld_valid && !ld_ready))
            && (stall_cnt != 8'hFF)) begin
            stall_d = stall_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            WE3          <= 1'b0;
            A3           <= '0;
            WD3          <= '0;
            stall_cnt    <= 8'd0;
            last_grant_q <= REQ_LD;
        end else begin
            WE3          <= we3_d;
            A3           <= a3_d;
            WD3          <= wd3_d;
            stall_cnt    <= stall_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Sequencer and arbiter for the 32x32 register file's single write port (WE3/A3/WD3). Two writeback requesters, ALU result and load data, share the port under valid/ready handshakes with round-robin arbitration on contention. An optional post-reset sequencer zero-clears x1..x31, because the register file's reset only masks reads and never clears its storage. Sits between the execute/memory writeback stages and the register file.

## Interface
Parameters:
- ADDR_W, 5, register address width
- DATA_W, 32, write data width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous reset, active-high
- alu_valid  in  1  ALU writeback request
- alu_ready  out  1  ALU request accepted this cycle when high with alu_valid
- alu_rd  in  ADDR_W  ALU destination register
- alu_wd  in  DATA_W  ALU write data
- ld_valid  in  1  load writeback request
- ld_ready  out  1  load request accepted this cycle when high with ld_valid
- ld_rd  in  ADDR_W  load destination register
- ld_wd  in  DATA_W  load write data
- WE3  out  1  register file write enable (registered)
- A3  out  ADDR_W  register file write address (registered)
- WD3  out  DATA_W  register file write data (registered)
- busy  out  1  clear sequence in progress
- stall_cnt  out  8  saturating count of cycles in which a valid request was not accepted

## Operation
- Reset values:
  - WE3=0, A3=0, WD3=0, stall_cnt=0.
  - last_grant=LD, so the ALU wins the first tie.
  - With CLEAR_ON_RESET_EN: state=CLEAR, clr_idx=1, busy=1.
  - Without CLEAR_ON_RESET_EN: state=RUN, busy=0.
- State CLEAR:
  - Each cycle: WE3<=1, A3<=clr_idx, WD3<=0, clr_idx increments.
  - alu_ready=ld_ready=0; requests are held by the requesters and not counted in stall_cnt.
  - After the clr_idx=31 write is registered: state<=RUN, busy<=0.
  - Address x0 is never driven.
- State RUN:
  - alu_ready and ld_ready are combinational from valids and last_grant; at most one is high per cycle.
  - Only one valid high: that requester gets ready=1.
  - Both valid high: the requester not equal to last_grant gets ready=1.
  - last_grant updates only on an accepted transfer (valid&ready).
  - On acceptance: A3<=rd, WD3<=wd, WE3<=(rd!=0).
  - No acceptance: WE3<=0; A3 and WD3 hold their previous values.
- x0 writes: the handshake completes normally, but WE3 stays 0.
- Same rd from both requesters in one cycle: they are serialized by arbitration order. The later writer's value persists.
- stall_cnt: increments in RUN each cycle where (alu_valid&!alu_ready)|(ld_valid&!ld_ready). Saturates at 255; clears only on reset.
- Requesters must hold valid, rd and wd stable until accepted.

## Timing
- Handshake-to-write latency: 1 cycle. A transfer accepted at edge N has WE3/A3/WD3 valid from edge N to edge N+1. The register file captures it at edge N+1.
- Throughput: one write per cycle. Under continuous contention, grants alternate ALU, LD, ALU, …
- Clear sequence: 31 cycles.
  - First rising edge with rst=0 registers A3=1.
  - The 31st edge registers A3=31 and sets state=RUN.
  - ready may assert in the cycle after that 31st edge.
- rst asserted mid-clear or mid-RUN: the next edge applies all reset values. Any in-flight registered write is dropped (WE3=0). The clear sequence restarts from x1.

## Configuration
- CLEAR_ON_RESET_EN defined: CLEAR state, clr_idx counter and busy=1 after reset are present, as described above.
- CLEAR_ON_RESET_EN undefined:
  - The CLEAR state and clr_idx counter are removed.
  - busy is tied to 0.
  - Arbitration starts on the first edge after reset.

## Structure
- Package regfile_pkg holds:
  - ADDR_W, DATA_W, NUM_REGS=32, ZERO_REG=0.
  - Requester enum {REQ_ALU=0, REQ_LD=1}.
  - State enum {ST_CLEAR, ST_RUN}.
- Sub-module rr_arb2: two-input round-robin arbiter.
  - Inputs: req[1:0], last_grant, en.
  - Output: one-hot gnt[1:0].
  - Combinational only; the last_grant register stays in the top level.

## Test plan
- Clear sequence (macro on): release rst -> WE3=1 for 31 consecutive cycles, A3=1..31, WD3=0; busy falls after A3=31; readies stay 0 throughout.
- Single requester: alu_valid with rd=5, wd=0xDEADBEEF -> alu_ready same cycle; next cycle WE3=1, A3=5, WD3=0xDEADBEEF.
- Contention: both valid for 4 cycles, with each requester's rd/wd fixed until its acceptance and then changed to a distinct new rd/wd (ALU rd=3,0x11 then 0x12; LD rd=4,0x22 then 0x23) -> grants ALU, LD, ALU, LD; 4 writes on consecutive cycles with the matching rd/wd; stall_cnt=4.
- x0 write: ld_valid with rd=0, wd=0xFFFFFFFF -> ld_ready=1; next cycle WE3=0.
- Reset mid-clear: assert rst when A3=10 -> next edge WE3=0; after release, the sequence restarts at A3=1.
- Saturation: hold ld_valid with alu_valid for 300 contended cycles -> stall_cnt reaches 255 and holds.
